// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD job dispatcher: state encoding, default
// core constants and counter sizing helper.
package gcd_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RESET  = 3'd1,
    LOAD   = 3'd2,
    RUN    = 3'd3,
    SETTLE = 3'd4,
    DONE   = 3'd5
  } gcd_state_e;

  localparam int GCD_FIN_ADDR = 9;
  localparam int GCD_WIDTH    = 32;
  localparam int GCD_ADDR_W   = 4;

  // Bits needed to hold (largest cycle count - 1); one counter width serves all uses.
  function automatic int gcd_cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/gcd_cycle_counter.sv
// Loadable down-counter with a zero flag; stops at zero.
module gcd_cycle_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: load wins over decrement, saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/gcd_dispatch.sv
// Job sequencer around the GCD core: reset, load, run, settle, present result.
// Define GCD_DISPATCH_TIMEOUT_EN to add a RUN-phase watchdog that flags out_err.
module gcd_dispatch
  import gcd_pkg::*;
#(
  parameter int WIDTH          = GCD_WIDTH,
  parameter int ADDR_W         = GCD_ADDR_W,
  parameter int FIN_ADDR       = GCD_FIN_ADDR,
  parameter int RST_CYCLES     = 2,
  parameter int SETTLE_CYCLES  = 10,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_g,
  output logic              out_err,
  output logic              core_rst,
  output logic              core_en,
  output logic              core_load,
  output logic [WIDTH-1:0]  core_a,
  output logic [WIDTH-1:0]  core_b,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [WIDTH-1:0]  core_res,
  output logic [15:0]       jobs_done
);

  localparam int CNT_W = gcd_cnt_width(RST_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES);

  gcd_state_e        state_q;
  logic              core_rst_q, core_en_q, core_load_q;
  logic [WIDTH-1:0]  core_a_q, core_b_q, out_g_q;
  logic              out_valid_q, out_err_q;
  logic [15:0]       jobs_done_q;

  logic              cnt_load_s, cnt_dec_s, cnt_zero_s;
  logic [CNT_W-1:0]  cnt_val_s;
  logic              fin_s, timeout_s;

  assign fin_s    = (core_addr == ADDR_W'(FIN_ADDR));
  assign in_ready = (state_q == IDLE);

  // Shared phase counter: loaded on accept and on finish, counts down in RESET/SETTLE.
  always_comb begin
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
    cnt_val_s  = {CNT_W{1'b0}};
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cnt_load_s = 1'b1;
          cnt_val_s  = CNT_W'(RST_CYCLES - 1);
        end else begin
          cnt_load_s = 1'b0;
        end
      end
      RESET:  cnt_dec_s = 1'b1;
      RUN: begin
        if (fin_s) begin
          cnt_load_s = 1'b1;
          cnt_val_s  = CNT_W'(SETTLE_CYCLES - 1);
        end else begin
          cnt_load_s = 1'b0;
        end
      end
      SETTLE: cnt_dec_s = 1'b1;
      default: cnt_dec_s = 1'b0;
    endcase
  end

  gcd_cycle_counter #(.W(CNT_W)) u_phase_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load_s),
    .load_val_i (cnt_val_s),
    .dec_i      (cnt_dec_s),
    .zero_o     (cnt_zero_s)
  );

`ifdef GCD_DISPATCH_TIMEOUT_EN
  logic wdog_zero_s;

  gcd_cycle_counter #(.W(CNT_W)) u_wdog_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (state_q == LOAD),
    .load_val_i (CNT_W'(TIMEOUT_CYCLES - 1)),
    .dec_i      (state_q == RUN),
    .zero_o     (wdog_zero_s)
  );

  assign timeout_s = wdog_zero_s;
`else
  assign timeout_s = 1'b0;
`endif

  // Sequencer FSM with registered core controls and result stream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      core_rst_q  <= 1'b1;
      core_en_q   <= 1'b0;
      core_load_q <= 1'b0;
      core_a_q    <= {WIDTH{1'b0}};
      core_b_q    <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      out_g_q     <= {WIDTH{1'b0}};
      out_err_q   <= 1'b0;
      jobs_done_q <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          core_rst_q  <= 1'b1;
          core_en_q   <= 1'b0;
          core_load_q <= 1'b0;
          if (in_valid) begin
            core_a_q <= in_a;
            core_b_q <= in_b;
            state_q  <= RESET;
          end
        end
        RESET: begin
          if (cnt_zero_s) begin
            core_rst_q  <= 1'b0;
            core_load_q <= 1'b1;
            state_q     <= LOAD;
          end
        end
        LOAD: begin
          core_load_q <= 1'b0;
          core_en_q   <= 1'b1;
          state_q     <= RUN;
        end
        RUN: begin
          if (fin_s) begin
            state_q <= SETTLE;
          end else if (timeout_s) begin
            out_g_q     <= core_res;
            out_err_q   <= 1'b1;
            out_valid_q <= 1'b1;
            core_en_q   <= 1'b0;
            state_q     <= DONE;
          end
        end
        SETTLE: begin
          if (cnt_zero_s) begin
            out_g_q     <= core_res;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b1;
            core_en_q   <= 1'b0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            jobs_done_q <= jobs_done_q + 16'd1;
            core_rst_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          core_rst_q <= 1'b1;
          core_en_q  <= 1'b0;
        end
      endcase
    end
  end

  assign core_rst  = core_rst_q;
  assign core_en   = core_en_q;
  assign core_load = core_load_q;
  assign core_a    = core_a_q;
  assign core_b    = core_b_q;
  assign out_valid = out_valid_q;
  assign out_g     = out_g_q;
  assign out_err   = out_err_q;
  assign jobs_done = jobs_done_q;

endmodule

// File: tb/tb_gcd_dispatch.sv
// Directed bench for gcd_dispatch with a behavioural Euclid core model.
module tb_gcd_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [31:0] in_a, in_b, out_g, core_a, core_b, core_res;
  logic        core_rst, core_en, core_load;
  logic [3:0]  core_addr;
  logic [15:0] jobs_done;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          load_cnt = 0;
  logic [15:0] exp_jobs = 16'd0;

  logic [31:0] ma, mb;
  logic [3:0]  maddr;
  bit          stall = 1'b0;

  always #5 clk = ~clk;

  gcd_dispatch #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_g(out_g), .out_err(out_err),
    .core_rst(core_rst), .core_en(core_en), .core_load(core_load),
    .core_a(core_a), .core_b(core_b), .core_addr(core_addr), .core_res(core_res),
    .jobs_done(jobs_done)
  );

  // Core model: one Euclid step per enabled cycle, address 9 once b reaches zero.
  always @(posedge clk) begin
    if (core_rst) begin
      ma <= 32'd0; mb <= 32'd0; maddr <= 4'd0;
    end else if (core_load) begin
      ma <= core_a; mb <= core_b;
      maddr <= (core_b == 32'd0) ? 4'd9 : 4'd0;
    end else if (core_en) begin
      if (stall) maddr <= 4'd1;
      else if (mb == 32'd0) maddr <= 4'd9;
      else begin ma <= mb; mb <= ma % mb; maddr <= 4'd1; end
    end
  end
  assign core_addr = maddr;
  assign core_res  = ma;

  always @(posedge clk) if (core_load) load_cnt <= load_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the result handshake.
  task automatic run_job(input logic [31:0] a, input logic [31:0] b, input logic [31:0] g,
                         input logic err, input bit keep_valid, input int hold);
    int lc0;
    in_a = a; in_b = b; in_valid = 1'b1;
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    lc0 = load_cnt;
    @(negedge clk);
    if (!keep_valid) in_valid = 1'b0;
    check("busy_after_accept", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 400 && !out_valid; i++) @(negedge clk);
    check("out_valid", {31'd0, out_valid}, 32'd1);
    check("out_g", out_g, g);
    check("out_err", {31'd0, out_err}, {31'd0, err});
    check("busy_at_result", {31'd0, in_ready}, 32'd0);
    check("load_pulses", load_cnt - lc0, 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_g", out_g, g);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_ready", {31'd0, in_ready}, 32'd0);
      check("hold_en", {31'd0, core_en}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_jobs = exp_jobs + 16'd1;
    check("valid_clear", {31'd0, out_valid}, 32'd0);
    check("ready_back", {31'd0, in_ready}, 32'd1);
    check("jobs_done", {16'd0, jobs_done}, {16'd0, exp_jobs});
  endtask

  logic [31:0] va [15] = '{32'd48, 32'd1071, 32'd17, 32'd100, 32'd0, 32'd7, 32'd13, 32'd270,
                           32'd1, 32'd81, 32'd12, 32'd35, 32'd1000, 32'd144, 32'd99};
  logic [31:0] vb [15] = '{32'd18, 32'd462, 32'd5, 32'd75, 32'd5, 32'd0, 32'd13, 32'd192,
                           32'd1, 32'd27, 32'd8, 32'd64, 32'd10, 32'd60, 32'd121};
  logic [31:0] vg [15] = '{32'd6, 32'd21, 32'd1, 32'd25, 32'd5, 32'd7, 32'd13, 32'd6,
                           32'd1, 32'd27, 32'd4, 32'd1, 32'd10, 32'd12, 32'd11};

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = 32'd0; in_b = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_core_rst", {31'd0, core_rst}, 32'd1);
    check("rst_core_en", {31'd0, core_en}, 32'd0);
    check("rst_core_load", {31'd0, core_load}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_g", out_g, 32'd0);
    check("rst_jobs", {16'd0, jobs_done}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run_job(32'd48, 32'd18, 32'd6, 1'b0, 1'b0, 0);

    run_job(32'd1071, 32'd462, 32'd21, 1'b0, 1'b1, 0);
    run_job(32'd17, 32'd5, 32'd1, 1'b0, 1'b1, 0);
    run_job(32'd100, 32'd75, 32'd25, 1'b0, 1'b0, 0);

    run_job(32'd12, 32'd8, 32'd4, 1'b0, 1'b1, 20);
    run_job(32'd35, 32'd64, 32'd1, 1'b0, 1'b0, 0);

    in_a = 32'd1071; in_b = 32'd462; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 50 && !core_en; i++) @(negedge clk);
    check("reached_run", {31'd0, core_en}, 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_core_rst", {31'd0, core_rst}, 32'd1);
    check("mid_rst_core_en", {31'd0, core_en}, 32'd0);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_out_g", out_g, 32'd0);
    check("mid_rst_core_a", core_a, 32'd0);
    check("mid_rst_jobs", {16'd0, jobs_done}, 32'd0);
    exp_jobs = 16'd0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_job(32'd48, 32'd18, 32'd6, 1'b0, 1'b0, 0);

    for (int i = 0; i < 15; i++) run_job(va[i], vb[i], vg[i], 1'b0, 1'b0, 0);

`ifdef GCD_DISPATCH_TIMEOUT_EN
    stall = 1'b1;
    run_job(32'd48, 32'd18, 32'd48, 1'b1, 1'b0, 0);
    stall = 1'b0;
    run_job(32'd48, 32'd18, 32'd6, 1'b0, 1'b0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_dispatch.md
Name: gcd_dispatch

Overview:
- Job sequencer wrapped around the GCD core (`top` with its `ctrl` microsequencer).
- Accepts operand pairs over a valid/ready stream, resets and loads the core, enables it, and detects program completion by watching the core's instruction address.
- After a settle interval it captures the result and presents it on a valid/ready output stream.
- Replaces the bench-driven reset/load/poll sequence so the core can run back-to-back jobs in hardware.

Parameters:
- WIDTH, 32, operand/result width.
- ADDR_W, 4, width of core instruction address.
- FIN_ADDR, 9, core address meaning "program finished".
- RST_CYCLES, 2, cycles core_rst is held per job (≥1).
- SETTLE_CYCLES, 10, cycles after FIN_ADDR seen before result capture (≥1).
- TIMEOUT_CYCLES, 4096, max RUN cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  dispatcher can accept a job.
- in_a  in  WIDTH  operand a.
- in_b  in  WIDTH  operand b.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_g  out  WIDTH  captured GCD.
- out_err  out  1  result invalid (timeout); constant 0 without the optional feature.
- core_rst  out  1  active-high reset to core.
- core_en  out  1  core enable.
- core_load  out  1  one-cycle strobe: core writes core_a/core_b into its a/b registers.
- core_a  out  WIDTH  operand a to core.
- core_b  out  WIDTH  operand b to core.
- core_addr  in  ADDR_W  core ctrl instruction address.
- core_res  in  WIDTH  core register a (result).
- jobs_done  out  16  completed-job counter.

Behaviour:
- Reset values (rst low, asynchronous):
  - state=IDLE, core_rst=1, core_en=0, core_load=0.
  - core_a=core_b=0, out_valid=0, out_g=0, out_err=0, jobs_done=0, counter=0.
- All outputs are registered except in_ready, which equals (state==IDLE).
- IDLE:
  - core_rst=1, core_en=0.
  - On in_valid&&in_ready: latch in_a/in_b into core_a/core_b, load counter=RST_CYCLES-1, go RESET.
- RESET:
  - core_rst=1, core_en=0.
  - Count down; at 0 go LOAD.
- LOAD (exactly 1 cycle):
  - core_rst=0, core_load=1, core_en=0.
  - Next state RUN.
- RUN:
  - core_en=1, core_load=0.
  - When core_addr==FIN_ADDR (sampled registered): load counter=SETTLE_CYCLES-1, go SETTLE.
- SETTLE:
  - core_en stays 1.
  - Count down; at 0: out_g<=core_res, out_err<=0, out_valid<=1, go DONE.
- DONE:
  - core_en=0, core_rst=0; out_g held stable.
  - On out_valid&&out_ready: out_valid<=0, jobs_done<=jobs_done+1 (wraps 0xFFFF→0), go IDLE.
- Latency:
  - Accept→out_valid = RST_CYCLES + 1 + run cycles + 1 + SETTLE_CYCLES.
  - Next job accepted no earlier than the cycle after the result handshake; no overlap.
- Simultaneous in_valid and out_ready in DONE: result completes; in_ready rises the following cycle.
- in_valid while busy: ignored (in_ready=0); upstream holds data.
- FIN_ADDR already present on the first RUN cycle: accepted immediately; the SETTLE path is still taken.
- Reset mid-job: immediate return to reset values; the in-flight job is dropped and no output is produced.

Optional Feature:
- Macro: GCD_DISPATCH_TIMEOUT_EN.
- Defined:
  - A RUN cycle counter starts at entry to RUN.
  - If it reaches TIMEOUT_CYCLES without FIN_ADDR: out_g<=core_res, out_err<=1, out_valid<=1, go DONE.
  - The completed-job counter is still incremented on the handshake.
- Undefined: no watchdog logic; out_err tied 0; RUN waits indefinitely.

Decomposition:
- Package gcd_pkg holds:
  - the state encoding (IDLE, RESET, LOAD, RUN, SETTLE, DONE);
  - default constants GCD_FIN_ADDR=9, GCD_WIDTH=32, GCD_ADDR_W=4.
- One sub-module, gcd_cycle_counter: loadable down-counter with zero flag, shared by RESET/SETTLE and (when enabled) the watchdog as a second instance.

Test Plan:
- Single job: a=48, b=18 → out_valid with out_g=6, out_err=0; jobs_done=1; core_load pulses exactly once.
- Back-to-back: (1071,462), (17,5), (100,75) streamed with in_valid held high → results 21, 1, 25 in order; in_ready low from accept until one cycle after each handshake.
- Output backpressure: out_ready low for 20 cycles after out_valid → out_g stable, no new accept, core_en=0; on release, jobs_done increments by exactly 1.
- Mid-run reset: assert rst low during RUN of (1071,462) → all outputs at reset values in the same cycle; a fresh job (48,18) afterwards yields 6.
- Full-vector regression: all 15 a/b/g vectors run through the real core at FIN_ADDR=9 → every out_g matches g.
- With GCD_DISPATCH_TIMEOUT_EN and TIMEOUT_CYCLES=16: core model never reaches FIN_ADDR → out_valid after 16 RUN cycles with out_err=1; next job clears out_err to 0.
